qed_dup_scheduler: RTL and testbench

Sequences the original/duplicate instruction stream for SQED on the picorv32 core. It sits between the symbolic instruction source and the core fetch interface:
- In ORIG mode it forwards constrained original instructions (registers x0–x15) and records them in a queue.
- On request, or when the queue fills, it switches to DUP mode and replays each queued instruction remapped to registers x16–x31 (and, optionally, to the upper memory half).
- It raises a one-cycle check pulse when original and duplicate counts match, which is the QED consistency checkpoint.

---
 rtl/qed_dup_scheduler.sv | 139 +++++++++++++
 tb/tb_qed_dup_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_scheduler.sv
// SQED original/duplicate instruction sequencer for picorv32 fetch.
// Optional macro QED_MEM_REMAP_EN: duplicates of loads/stores also target the upper memory half.
module qed_dup_scheduler #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ifu_instr,
   input  logic             ifu_valid,
   output logic             ifu_ready,
   input  logic             exec_dup,
   output logic [31:0]      qed_instr,
   output logic             qed_valid,
   input  logic             qed_ready,
   output logic             qed_mode,
   output logic [CNT_W-1:0] qed_orig_count,
   output logic [CNT_W-1:0] qed_dup_count,
   output logic             qed_check
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0]    PTR_ONE  = 1;
   localparam logic [AW:0]      LVL_ONE  = 1;
   localparam logic [AW:0]      LVL_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_NOP    = 7'b1111111;

   typedef enum logic {ORIG, DUP} state_t;

   state_t           state, state_nxt;
   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      level;
   logic             full, empty, sw, push, pop, last_pop;
   logic [31:0]      dup_instr;
   logic [CNT_W-1:0] orig_nxt, dup_nxt;

   // Originals use x0-x15 only, so setting bit 4 of a nonzero field maps xN to x(N+16).
   function automatic logic [31:0] remap(input logic [31:0] ins);
      logic [31:0] r;
      logic [2:0]  use_f;
      r     = ins;
      use_f = 3'b000;
      case (ins[6:0])
         OP_R:                     use_f = 3'b111;
         OP_IALU, OP_LOAD:         use_f = 3'b110;
         OP_STORE, OP_BRANCH:      use_f = 3'b011;
         OP_JALR:                  use_f = 3'b110;
         OP_LUI, OP_AUIPC, OP_JAL: use_f = 3'b100;
         default:                  use_f = 3'b000;
      endcase
      if (use_f[2] && ins[11:7]  != 5'd0) r[11] = 1'b1;
      if (use_f[1] && ins[19:15] != 5'd0) r[19] = 1'b1;
      if (use_f[0] && ins[24:20] != 5'd0) r[24] = 1'b1;
`ifdef QED_MEM_REMAP_EN
      if (ins[6:0] == OP_LOAD || ins[6:0] == OP_STORE) r[26] = 1'b1;
`endif
      return r;
   endfunction

   assign full      = (level == LVL_FULL);
   assign empty     = (level == '0);
   assign sw        = full || (exec_dup && !empty);
   assign dup_instr = remap(mem[rd_ptr]);
   assign qed_mode  = (state == DUP);

   always_comb begin
      state_nxt = state;
      ifu_ready = 1'b0;
      qed_valid = 1'b0;
      qed_instr = ifu_instr;
      push      = 1'b0;
      pop       = 1'b0;
      case (state)
         ORIG: begin
            if (sw) begin
               state_nxt = DUP;
            end else begin
               qed_valid = ifu_valid;
               ifu_ready = qed_ready;
               push      = ifu_valid && qed_ready && (ifu_instr[6:0] != OP_NOP);
            end
         end
         DUP: begin
            qed_instr = dup_instr;
            qed_valid = !empty;
            pop       = !empty && qed_ready;
            if (empty || (pop && level == LVL_ONE)) state_nxt = ORIG;
         end
         default: state_nxt = ORIG;
      endcase
   end

   assign last_pop = pop && (level == LVL_ONE);
   assign orig_nxt = (push && qed_orig_count != CNT_MAX) ? qed_orig_count + CNT_ONE : qed_orig_count;
   assign dup_nxt  = (pop && qed_dup_count != CNT_MAX) ? qed_dup_count + CNT_ONE : qed_dup_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ORIG;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         qed_orig_count <= '0;
         qed_dup_count  <= '0;
         qed_check      <= 1'b0;
      end else begin
         state          <= state_nxt;
         qed_orig_count <= orig_nxt;
         qed_dup_count  <= dup_nxt;
         qed_check      <= last_pop && (orig_nxt == dup_nxt) && (dup_nxt != '0);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            level  <= level + LVL_ONE;
         end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            level  <= level - LVL_ONE;
         end
      end
   end

   // Storage needs no reset: pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ifu_instr;
   end

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Directed bench for qed_dup_scheduler: pass-through, remap, fill, NOP, stall, reset, saturation.
module tb_qed_dup_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_instr;
   logic        ifu_valid;
   logic        ifu_ready;
   logic        exec_dup;
   logic [31:0] qed_instr;
   logic        qed_valid;
   logic        qed_ready;
   logic        qed_mode;
   logic [7:0]  qed_orig_count;
   logic [7:0]  qed_dup_count;
   logic        qed_check;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] expq [16];
   logic [31:0] NOP_I   = 32'h0000007F;
   logic [31:0] ADD_I   = 32'h003100B3;
   logic [31:0] ADD_D   = 32'h013908B3;
   logic [31:0] LW_I    = 32'h00402083;
`ifdef QED_MEM_REMAP_EN
   logic [31:0] LW_D    = 32'h04402883;
`else
   logic [31:0] LW_D    = 32'h00402883;
`endif

   qed_dup_scheduler #(.DEPTH(16), .CNT_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .ifu_instr      (ifu_instr),
      .ifu_valid      (ifu_valid),
      .ifu_ready      (ifu_ready),
      .exec_dup       (exec_dup),
      .qed_instr      (qed_instr),
      .qed_valid      (qed_valid),
      .qed_ready      (qed_ready),
      .qed_mode       (qed_mode),
      .qed_orig_count (qed_orig_count),
      .qed_dup_count  (qed_dup_count),
      .qed_check      (qed_check)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   // Expected duplicate of an ADDI: x16 added to each nonzero register.
   function automatic logic [31:0] addi_dup(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      logic [4:0] drd, drs;
      drd = (rd  == 5'd0) ? 5'd0 : rd  + 5'd16;
      drs = (rs1 == 5'd0) ? 5'd0 : rs1 + 5'd16;
      return {imm, drs, 3'b000, drd, 7'b0010011};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      ifu_valid = 1'b0;
      exec_dup  = 1'b0;
      qed_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ifu_instr = '0; ifu_valid = 1'b0; exec_dup = 1'b0; qed_ready = 1'b0;
      tick();
      ifu_valid = 1'b1; ifu_instr = NOP_I; #1;
      chk("rst_mode", {31'd0, qed_mode}, 32'd0);
      chk("rst_orig", {24'd0, qed_orig_count}, 32'd0);
      chk("rst_dup", {24'd0, qed_dup_count}, 32'd0);
      chk("rst_check", {31'd0, qed_check}, 32'd0);
      chk("rst_valid1", {31'd0, qed_valid}, 32'd1);
      ifu_valid = 1'b0; #1;
      chk("rst_valid0", {31'd0, qed_valid}, 32'd0);
      rst = 1'b0;
      tick();

      // ADD x1,x2,x3 forwarded, then duplicated
      ifu_instr = ADD_I; ifu_valid = 1'b1; qed_ready = 1'b1; #1;
      chk("add_pass_instr", qed_instr, ADD_I);
      chk("add_pass_valid", {31'd0, qed_valid}, 32'd1);
      chk("add_ifu_ready", {31'd0, ifu_ready}, 32'd1);
      tick();
      ifu_valid = 1'b0; exec_dup = 1'b1; #1;
      chk("add_orig1", {24'd0, qed_orig_count}, 32'd1);
      chk("sw_valid", {31'd0, qed_valid}, 32'd0);
      chk("sw_ifu_ready", {31'd0, ifu_ready}, 32'd0);
      tick();
      exec_dup = 1'b0; #1;
      chk("add_mode_dup", {31'd0, qed_mode}, 32'd1);
      chk("add_dup_valid", {31'd0, qed_valid}, 32'd1);
      chk("add_dup_instr", qed_instr, ADD_D);
      tick();
      chk("add_check", {31'd0, qed_check}, 32'd1);
      chk("add_dupcnt", {24'd0, qed_dup_count}, 32'd1);
      chk("add_mode_orig", {31'd0, qed_mode}, 32'd0);
      tick();
      chk("add_check_once", {31'd0, qed_check}, 32'd0);

      // LW x1,4(x0)
      ifu_instr = LW_I; ifu_valid = 1'b1; tick();
      ifu_valid = 1'b0; exec_dup = 1'b1; tick();
      exec_dup = 1'b0; #1;
      chk("lw_dup_instr", qed_instr, LW_D);
      tick();
      chk("lw_check", {31'd0, qed_check}, 32'd1);
      chk("lw_counts", {16'd0, qed_orig_count, qed_dup_count}, 32'h0202);

      // Fill the queue: full forces DUP
      do_reset();
      qed_ready = 1'b1; ifu_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ifu_instr = addi(5'(i), 5'(15 - i), 12'(i * 3));
         expq[i]   = addi_dup(5'(i), 5'(15 - i), 12'(i * 3));
         #1;
         chk("fill_ifu_ready", {31'd0, ifu_ready}, 32'd1);
         tick();
      end
      ifu_instr = ADD_I; #1;
      chk("full_ifu_ready", {31'd0, ifu_ready}, 32'd0);
      chk("full_valid", {31'd0, qed_valid}, 32'd0);
      chk("full_orig", {24'd0, qed_orig_count}, 32'd16);
      tick();
      ifu_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("fill_dup_mode", {31'd0, qed_mode}, 32'd1);
         chk("fill_dup_instr", qed_instr, expq[i]);
         tick();
      end
      chk("fill_check", {31'd0, qed_check}, 32'd1);
      chk("fill_counts", {16'd0, qed_orig_count, qed_dup_count}, 32'h1010);
      chk("fill_mode", {31'd0, qed_mode}, 32'd0);

      // NOPs interleaved with 3 ADDIs
      do_reset();
      qed_ready = 1'b1; ifu_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         ifu_instr = (i % 2 == 0) ? NOP_I : addi(5'(i), 5'(i + 1), 12'h7F0);
         #1;
         chk("nop_pass", qed_instr, ifu_instr);
         tick();
      end
      ifu_valid = 1'b0; exec_dup = 1'b1; #1;
      chk("nop_orig3", {24'd0, qed_orig_count}, 32'd3);
      tick();
      exec_dup = 1'b0;
      for (int k = 1; k < 6; k += 2) begin
         #1;
         chk("nop_dup_instr", qed_instr, addi_dup(5'(k), 5'(k + 1), 12'h7F0));
         tick();
      end
      chk("nop_mode", {31'd0, qed_mode}, 32'd0);
      chk("nop_counts", {16'd0, qed_orig_count, qed_dup_count}, 32'h0303);
      chk("nop_check", {31'd0, qed_check}, 32'd1);

      // Stall in DUP, then reset after two pops
      do_reset();
      qed_ready = 1'b1; ifu_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ifu_instr = addi(5'(i + 1), 5'(i + 2), 12'(i));
         expq[i]   = addi_dup(5'(i + 1), 5'(i + 2), 12'(i));
         tick();
      end
      exec_dup = 1'b1; tick();
      qed_ready = 1'b0; ifu_valid = 1'b1; ifu_instr = ADD_I;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_instr", qed_instr, expq[0]);
         chk("stall_valid", {31'd0, qed_valid}, 32'd1);
         chk("stall_ifu_ready", {31'd0, ifu_ready}, 32'd0);
         chk("stall_dupcnt", {24'd0, qed_dup_count}, 32'd0);
         tick();
      end
      exec_dup = 1'b0; ifu_valid = 1'b0; qed_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("pre_rst_instr", qed_instr, expq[i]);
         tick();
      end
      chk("pre_rst_dupcnt", {24'd0, qed_dup_count}, 32'd2);
      rst = 1'b1; #1;
      chk("mid_rst_mode", {31'd0, qed_mode}, 32'd0);
      chk("mid_rst_counts", {16'd0, qed_orig_count, qed_dup_count}, 32'd0);
      chk("mid_rst_check", {31'd0, qed_check}, 32'd0);
      tick();
      rst = 1'b0;
      ifu_valid = 1'b1; ifu_instr = NOP_I; exec_dup = 1'b1; #1;
      chk("post_rst_pass", {31'd0, qed_valid}, 32'd1);
      chk("post_rst_instr", qed_instr, NOP_I);
      tick();
      chk("empty_exec_ignored", {31'd0, qed_mode}, 32'd0);
      exec_dup = 1'b0; ifu_valid = 1'b0;

      // Counter saturation: 256 originals and duplicates
      do_reset();
      qed_ready = 1'b1;
      for (int r = 0; r < 16; r++) begin
         ifu_valid = 1'b1;
         for (int i = 0; i < 16; i++) begin
            ifu_instr = addi(5'(i), 5'(i), 12'(r));
            tick();
         end
         ifu_valid = 1'b0;
         tick();
         for (int i = 0; i < 16; i++) tick();
      end
      chk("sat_orig", {24'd0, qed_orig_count}, 32'd255);
      chk("sat_dup", {24'd0, qed_dup_count}, 32'd255);
      chk("sat_check", {31'd0, qed_check}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
